// File: rtl/fft_bfp_scaler.sv
// Single-buffered block-floating-point scaler between FFT butterfly stages.
// Buffers one frame, applies a 1-bit arithmetic right shift on overflow, tracks the block exponent.
`timescale 1ns/1ps
module fft_bfp_scaler #(
  parameter int N       = 3,
  parameter int FFT_PTS = 8,
  parameter int EXPW    = 2,
  localparam int W      = 2**N,
  localparam int IW     = $clog2(FFT_PTS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    s_data,
  input  logic            s_valid,
  input  logic            s_first,
  output logic            s_ready,
  output logic [W-1:0]    m_data,
  output logic            m_valid,
  output logic            m_last,
  output logic [EXPW-1:0] m_exp,
  input  logic            m_ready
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t            state_reg;
  logic [IW-1:0]     idx_reg;
  logic [EXPW-1:0]   exp_reg;
  logic              shift_reg;
  logic              ovf_reg;
  logic              first_reg;
  logic [W-1:0]      m_data_reg;
  logic              m_last_reg;
  logic              m_valid_reg;
  logic              s_ready_reg;

  logic [W-1:0]      buf_mem [FFT_PTS];

  logic              accept;
  logic              out_hs;
  logic              last_idx;
  logic [IW-1:0]     idx_inc;
  logic              ovf_next;
  logic [EXPW-1:0]   exp_base;
  logic [EXPW:0]     exp_sum;
  logic [EXPW-1:0]   exp_next;

  function automatic logic [W-1:0] scale(input logic [W-1:0] d, input logic sh);
    return sh ? {d[W-1], d[W-1:1]} : d;
  endfunction

  always_comb begin
    accept   = s_valid & s_ready_reg;
    out_hs   = m_valid_reg & m_ready;
    last_idx = (idx_reg == IW'(FFT_PTS-1));
    idx_inc  = idx_reg + IW'(1);
    // A sample has lost its guard bit when the two MSBs disagree.
    ovf_next = ((idx_reg == '0) ? 1'b0 : ovf_reg) | (s_data[W-1] ^ s_data[W-2]);
    exp_base = first_reg ? '0 : exp_reg;
    exp_sum  = {1'b0, exp_base} + (EXPW+1)'(ovf_next);
    exp_next = exp_sum[EXPW] ? '1 : exp_sum[EXPW-1:0];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_mem[idx_reg] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FILL;
      idx_reg     <= '0;
      exp_reg     <= '0;
      shift_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
      first_reg   <= 1'b0;
      m_data_reg  <= '0;
      m_last_reg  <= 1'b0;
      m_valid_reg <= 1'b0;
      s_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        FILL: begin
          if (accept) begin
            ovf_reg <= ovf_next;
            if (idx_reg == '0) begin
              first_reg <= s_first;
            end
            if (last_idx) begin
              state_reg   <= DRAIN;
              idx_reg     <= '0;
              shift_reg   <= ovf_next;
              exp_reg     <= exp_next;
              s_ready_reg <= 1'b0;
              m_valid_reg <= 1'b1;
              // Entry 0 was written earlier in the frame, so it can be prefetched now.
              m_data_reg  <= scale(buf_mem[0], ovf_next);
              m_last_reg  <= 1'b0;
            end else begin
              idx_reg <= idx_inc;
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (last_idx) begin
              state_reg   <= FILL;
              idx_reg     <= '0;
              s_ready_reg <= 1'b1;
              m_valid_reg <= 1'b0;
              m_data_reg  <= '0;
              m_last_reg  <= 1'b0;
            end else begin
              idx_reg    <= idx_inc;
              m_data_reg <= scale(buf_mem[idx_inc], shift_reg);
              m_last_reg <= (idx_inc == IW'(FFT_PTS-1));
            end
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  assign s_ready = s_ready_reg;
  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;
  assign m_last  = m_last_reg;
  assign m_exp   = exp_reg;

endmodule

// File: tb/tb_fft_bfp_scaler.sv
// Scoreboard bench for fft_bfp_scaler: frame-level reference model feeds a queue,
// a negedge monitor compares every presented output against the queue head.
`timescale 1ns/1ps
module tb_fft_bfp_scaler;
  localparam int N    = 3;
  localparam int W    = 8;
  localparam int PTS  = 8;
  localparam int EXPW = 2;
  localparam int EMAX = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [W-1:0]    s_data;
  logic            s_valid;
  logic            s_first;
  logic            s_ready;
  logic [W-1:0]    m_data;
  logic            m_valid;
  logic            m_last;
  logic [EXPW-1:0] m_exp;
  logic            m_ready;

  always #5 clk = ~clk;

  fft_bfp_scaler #(.N(N), .FFT_PTS(PTS), .EXPW(EXPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_first(s_first), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_exp(m_exp), .m_ready(m_ready)
  );

  typedef struct packed {
    logic [W-1:0]    d;
    logic            last;
    logic [EXPW-1:0] e;
  } out_t;

  out_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   out_idx = 0;
  bit   bp_active = 0;
  int   bp_cnt = 0;
  int   model_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  // Output monitor
  always @(negedge clk) begin
    out_t e;
    if (rst_n) begin
      if (m_valid) begin
        check("s_ready_low_in_drain", 32'(s_ready), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output act=%0h req=none", m_data);
        end else begin
          e = sb[0];
          check("out_sample", 32'({m_data, m_last, m_exp}), 32'(e));
          if (m_ready) begin
            $display("out idx=%0d data=%02h last=%0b exp=%0d", out_idx, m_data, m_last, m_exp);
            void'(sb.pop_front());
            out_idx = (out_idx + 1) % PTS;
          end
        end
      end else begin
        check("s_ready_high_in_fill", 32'(s_ready), 32'd1);
      end
    end
  end

  // Downstream ready: random, or a deterministic 3-cycle stall at sample 4
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_active) begin
        if (out_idx == 4 && bp_cnt < 3 && m_valid) begin
          m_ready = 1'b0;
          bp_cnt++;
        end else begin
          m_ready = 1'b1;
        end
      end else begin
        m_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic send_sample(input logic [W-1:0] d, input logic f, input bit is_last);
    int waited;
    waited = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_first = f;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      waited++;
      if (waited > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout act=s_ready_low req=s_ready_high");
        break;
      end
    end
    if (is_last) check("m_valid_before_last_accept", 32'(m_valid), 32'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_first = 1'b0;
    if (is_last) check("m_valid_one_cycle_after_last", 32'(m_valid), 32'd1);
  endtask

  // Reference model: a frame overflows if any sample lies outside [-2^(W-2), 2^(W-2)-1];
  // such a frame is halved (floor division) and bumps the exponent, saturating.
  task automatic send_frame(input logic [W-1:0] fr [PTS], input bit first, input int stray_idx,
                            input int gap_mode);
    bit ovf;
    int v;
    int ngap;
    out_t o;
    ovf = 0;
    for (int i = 0; i < PTS; i++) begin
      v = int'($signed(fr[i]));
      if (v > (2**(W-2) - 1) || v < -(2**(W-2))) ovf = 1;
    end
    if (first) model_exp = 0;
    model_exp = model_exp + int'(ovf);
    if (model_exp > EMAX) model_exp = EMAX;
    for (int i = 0; i < PTS; i++) begin
      v = int'($signed(fr[i]));
      if (ovf) v = v >>> 1;
      o.d    = W'(v);
      o.last = (i == PTS - 1);
      o.e    = EXPW'(model_exp);
      sb.push_back(o);
    end
    $display("frame first=%0b ovf=%0b exp=%0d gaps=%0d", first, ovf, model_exp, gap_mode);
    for (int i = 0; i < PTS; i++) begin
      ngap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (ngap) begin
        @(posedge clk);
        #1;
      end
      send_sample(fr[i], (i == 0) ? first : (i == stray_idx), i == PTS - 1);
    end
  endtask

  task automatic make_frame(input bit want_ovf, output logic [W-1:0] fr [PTS]);
    for (int i = 0; i < PTS; i++) begin
      if (want_ovf) fr[i] = W'($urandom_range(0, 255));
      else fr[i] = W'(int'($urandom_range(0, 127)) - 64);
    end
    if (want_ovf) fr[$urandom_range(0, PTS-1)] = W'($urandom_range(64, 127));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout act=%0d req=0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] fr [PTS];
    int t;
    s_valid = 1'b0;
    s_data  = '0;
    s_first = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_s_ready", 32'(s_ready), 32'd1);
    check("reset_m_valid", 32'(m_valid), 32'd0);
    check("reset_m_last", 32'(m_last), 32'd0);
    check("reset_m_data", 32'(m_data), 32'd0);
    check("reset_m_exp", 32'(m_exp), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // No overflow
    fr = '{8'h10, 8'hF0, 8'h3F, 8'hC0, 8'h00, 8'h01, 8'hFF, 8'h20};
    send_frame(fr, 1, -1, 0);
    // Overflow, shift applied
    fr = '{8'h50, 8'hF0, 8'h81, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(fr, 1, -1, 0);
    // Exponent accumulation and saturation
    for (int k = 0; k < 4; k++) begin
      make_frame(1, fr);
      send_frame(fr, k == 0, -1, 0);
    end
    make_frame(0, fr);
    send_frame(fr, 1, -1, 0);
    wait_drain();

    // Backpressure at sample 4
    bp_cnt = 0;
    bp_active = 1;
    make_frame(0, fr);
    send_frame(fr, 1, -1, 0);
    wait_drain();
    bp_active = 0;
    check("backpressure_cycles", 32'(bp_cnt), 32'd3);

    // Input gaps and stray s_first on a non-first frame
    make_frame(1, fr);
    send_frame(fr, 0, 3, 1);
    make_frame(1, fr);
    send_frame(fr, 0, 5, 2);
    wait_drain();

    // Reset during drain at index 2
    make_frame(1, fr);
    send_frame(fr, 0, -1, 0);
    t = 0;
    while (out_idx != 2 && t < 300) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("reset_point_reached", 32'(out_idx), 32'd2);
    rst_n = 1'b0;
    #1;
    check("async_reset_m_valid", 32'(m_valid), 32'd0);
    check("async_reset_s_ready", 32'(s_ready), 32'd1);
    check("async_reset_m_data", 32'(m_data), 32'd0);
    check("async_reset_m_last", 32'(m_last), 32'd0);
    check("async_reset_m_exp", 32'(m_exp), 32'd0);
    sb.delete();
    out_idx = 0;
    model_exp = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    make_frame(1, fr);
    send_frame(fr, 0, -1, 0);

    // Randomized frames
    for (int k = 0; k < 20; k++) begin
      make_frame($urandom_range(0, 1) == 1, fr);
      send_frame(fr, $urandom_range(0, 3) == 0, int'($urandom_range(1, PTS-1)),
                 int'($urandom_range(0, 2)));
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

endmodule
